// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the stereo DAC stream scheduler.
// Holds the scheduler state encoding, gain format and underrun counter helper.
package dac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } dac_state_t;

    localparam int GAIN_W = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
    localparam int UCNT_W = 16;

    // Saturating increment so a long outage never wraps back to a small count.
    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        if (v == {UCNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/dac_stream_scheduler_if.sv
// Upstream PCM stream: valid/ready handshake carrying one stereo sample pair.
interface dac_stream_scheduler_if #(
    parameter int DW = 24
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_l;
    logic [DW-1:0] s_r;

    modport master (output s_valid, output s_l, output s_r, input s_ready);
    modport slave  (input s_valid, input s_l, input s_r, output s_ready);
endinterface

// File: rtl/stereo_fifo2.sv
// Two-entry {left,right} sample FIFO with synchronous flush.
// A flush wins over a push or pop issued on the same edge.
module stereo_fifo2 #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [DW-1:0] i_l,
    input  logic [DW-1:0] i_r,
    output logic [DW-1:0] o_l,
    output logic [DW-1:0] o_r,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem_l [2];
    logic [DW-1:0] r_mem_r [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_l     = r_mem_l[r_rd_ptr];
    assign o_r     = r_mem_r[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sample storage; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wr_ptr] <= i_l;
            r_mem_r[r_wr_ptr] <= i_r;
        end
    end

endmodule

// File: rtl/dac_stream_scheduler.sv
// Feeds the stereo sigma-delta DAC core: strobe generation, per-sample hold,
// click-free linear gain ramp on start/stop and underrun accounting.
module dac_stream_scheduler
    import dac_ctrl_pkg::*;
#(
    parameter int DW        = 24,
    parameter int CLK_DIV   = 4,
    parameter int OSR       = 64,
    parameter int RAMP_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    dac_stream_scheduler_if.slave s_if,
    output logic                  dac_valid,
    output logic [DW-1:0]         dac_l,
    output logic [DW-1:0]         dac_r,
    output logic [1:0]            state,
    output logic                  underrun,
    output logic [UCNT_W-1:0]     underrun_cnt
);

    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OSR_W     = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int GAIN_FRAC = 8;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [OSR_W-1:0]  OSR_LAST  = OSR_W'(OSR - 1);
    localparam logic [GAIN_W-1:0] STEP_G    = GAIN_W'(RAMP_STEP);
    localparam logic [GAIN_W:0]   STEP_EXT  = (GAIN_W + 1)'(RAMP_STEP);
    localparam logic [GAIN_W:0]   UNITY_EXT = {1'b0, GAIN_UNITY};

    dac_state_t          r_state;
    dac_state_t          w_state_nxt;
    logic [GAIN_W-1:0]   r_gain;
    logic [GAIN_W-1:0]   w_gain_nxt;
    logic [GAIN_W:0]     w_gain_up;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [OSR_W-1:0]    r_osr_cnt;
    logic                r_dac_valid;
    logic [DW-1:0]       r_dac_l;
    logic [DW-1:0]       r_dac_r;
    logic                r_underrun;
    logic [UCNT_W-1:0]   r_ucnt;
    logic                w_tick;
    logic                w_boundary;
    logic                w_flush;
    logic                w_active;
    logic                w_pop;
    logic                w_under;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [DW-1:0]       w_fifo_l;
    logic [DW-1:0]       w_fifo_r;
    logic [DW-1:0]       w_samp_l;
    logic [DW-1:0]       w_samp_r;

    // Signed sample times unsigned Q1.8 gain; DW+10 bits holds the full product.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s,
                                            input logic [GAIN_W-1:0] g);
        logic signed [DW+9:0] p;
        p = $signed({{10{s[DW-1]}}, s}) * $signed({{(DW + 1){1'b0}}, g});
        p = p >>> GAIN_FRAC;
        return p[DW-1:0];
    endfunction

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_tick && (r_osr_cnt == OSR_LAST);
    assign w_gain_up  = {1'b0, r_gain} + STEP_EXT;

    stereo_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (s_if.s_valid && s_if.s_ready),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_l     (s_if.s_l),
        .i_r     (s_if.s_r),
        .o_l     (w_fifo_l),
        .o_r     (w_fifo_r),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign s_if.s_ready = !w_fifo_full;

    // State and gain register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gain  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    // Ramp sequencing: gain moves only at sample boundaries, enable edges act at once.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_boundary && enable) begin
                    w_state_nxt = ST_RAMP_UP;
                    w_gain_nxt  = STEP_G;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RAMP_UP: begin
                if (!enable) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else if (w_boundary) begin
                    if (w_gain_up >= UNITY_EXT) begin
                        w_gain_nxt  = GAIN_UNITY;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_gain_nxt  = w_gain_up[GAIN_W-1:0];
                    end
                end else begin
                    w_state_nxt = ST_RAMP_UP;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else begin
                    w_gain_nxt  = GAIN_UNITY;
                end
            end
            ST_RAMP_DOWN: begin
                if (enable) begin
                    w_state_nxt = ST_RAMP_UP;
                end else if (w_boundary) begin
                    if ({1'b0, r_gain} <= STEP_EXT) begin
                        w_gain_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                        w_flush     = 1'b1;
                    end else begin
                        w_gain_nxt  = r_gain - STEP_G;
                    end
                end else begin
                    w_state_nxt = ST_RAMP_DOWN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gain_nxt  = '0;
            end
        endcase
    end

    // Sample fetch: decided on the post-update state, so the IDLE->RAMP_UP edge already plays.
    always_comb begin
        w_active = w_boundary && (w_state_nxt != ST_IDLE);
        w_pop    = w_active && !w_fifo_empty;
        w_under  = w_active && w_fifo_empty;
        if (w_pop) begin
            w_samp_l = w_fifo_l;
            w_samp_r = w_fifo_r;
        end else begin
            w_samp_l = '0;
            w_samp_r = '0;
        end
    end

    // Strobe/slot counters and all registered DAC-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_osr_cnt   <= '0;
            r_dac_valid <= 1'b0;
            r_dac_l     <= '0;
            r_dac_r     <= '0;
            r_underrun  <= 1'b0;
            r_ucnt      <= '0;
        end else begin
            r_dac_valid <= w_tick;
            r_underrun  <= w_under;
            if (w_tick) begin
                r_div_cnt <= '0;
                r_osr_cnt <= (r_osr_cnt == OSR_LAST) ? '0 : r_osr_cnt + OSR_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_under) begin
                r_ucnt <= sat_inc(r_ucnt);
            end
            if (w_boundary) begin
                r_dac_l <= scale(w_samp_l, w_gain_nxt);
                r_dac_r <= scale(w_samp_r, w_gain_nxt);
            end
        end
    end

    assign dac_valid    = r_dac_valid;
    assign dac_l        = r_dac_l;
    assign dac_r        = r_dac_r;
    assign state        = r_state;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_dac_stream_scheduler.sv
// Scoreboard bench for dac_stream_scheduler with CLK_DIV=4, OSR=4, RAMP_STEP=64:
// each stimulus slot queues the hand-computed result of its closing sample boundary.
module tb_dac_stream_scheduler;

    localparam int DW = 24;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [1:0]  st;
        logic        u;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        dac_valid;
    logic [23:0] dac_l;
    logic [23:0] dac_r;
    logic [1:0]  state;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   pulse_n = 0;
    exp_t q[$];

    dac_stream_scheduler_if #(.DW(DW)) s_if ();

    dac_stream_scheduler #(
        .DW(DW), .CLK_DIV(4), .OSR(4), .RAMP_STEP(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_if         (s_if),
        .dac_valid    (dac_valid),
        .dac_l        (dac_l),
        .dac_r        (dac_r),
        .state        (state),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release; boundaries land on multiples of 16.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) cyc = 0;
            else     cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] pl, input logic [23:0] pr);
        logic ok;
        ok = 1'b0;
        s_if.s_l     = pl;
        s_if.s_r     = pr;
        s_if.s_valid = 1'b1;
        for (int k = 0; k < 8 && !ok; k++) begin
            ok = s_if.s_ready;
            step();
        end
        s_if.s_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic slot(input logic en, input int npush, input int dly,
                        input logic [23:0] pl, input logic [23:0] pr,
                        input logic [23:0] el, input logic [23:0] er,
                        input logic [1:0] est, input logic eu, input logic [15:0] ecnt);
        exp_t e;
        e.l = el; e.r = er; e.st = est; e.u = eu; e.cnt = ecnt;
        q.push_back(e);
        enable = en;
        repeat (dly) step();
        for (int n = 0; n < npush; n++) push(pl, pr);
        do step(); while (cyc % 16 != 0);
    endtask

    task automatic reset_checks();
        chk("rst_dac_l", 32'(dac_l), 32'd0);
        chk("rst_dac_r", 32'(dac_r), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_s_ready", 32'(s_if.s_ready), 32'd1);
        chk("rst_dac_valid", 32'(dac_valid), 32'd0);
    endtask

    // Monitor: every 4th strobe is a sample boundary and consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pulse_n = 0;
            end else if (dac_valid) begin
                pulse_n++;
                if (pulse_n % 4 == 0) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL boundary_expectation: got boundary with empty queue (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                        chk("dac_l", 32'(dac_l), 32'(e.l));
                        chk("dac_r", 32'(dac_r), 32'(e.r));
                        chk("state", 32'(state), 32'(e.st));
                        chk("underrun", 32'(underrun), 32'(e.u));
                        chk("underrun_cnt", 32'(underrun_cnt), 32'(e.cnt));
                    end
                end else begin
                    chk("underrun_midslot", 32'(underrun), 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_l     = '0;
        s_if.s_r     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and strobe cadence.
        reset_checks();
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("strobe_cadence", 32'(dac_valid), 32'((i % 4) == 0));
        end

        // Ramp up from IDLE, one sample per slot.
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h100000, 24'h080000, 2'd1, 1'b0, 16'd0);
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h200000, 24'h100000, 2'd1, 1'b0, 16'd0);
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h300000, 24'h180000, 2'd1, 1'b0, 16'd0);
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h400000, 24'h200000, 2'd2, 1'b0, 16'd0);

        // Negative samples through unity and a partial ramp down.
        slot(1'b1, 1, 0, 24'hC00000, 24'h400000, 24'hC00000, 24'h400000, 2'd2, 1'b0, 16'd0);
        slot(1'b0, 1, 0, 24'hC00000, 24'h400000, 24'hD00000, 24'h300000, 2'd3, 1'b0, 16'd0);
        slot(1'b0, 1, 0, 24'hC00000, 24'h400000, 24'hE00000, 24'h200000, 2'd3, 1'b0, 16'd0);

        // Re-enable during ramp down at gain 128.
        slot(1'b1, 1, 0, 24'h400000, 24'hC00000, 24'h300000, 24'hD00000, 2'd1, 1'b0, 16'd0);
        slot(1'b1, 1, 0, 24'h400000, 24'hC00000, 24'h400000, 24'hC00000, 2'd2, 1'b0, 16'd0);

        // Underrun, then a push arriving mid-slot.
        slot(1'b1, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 2'd2, 1'b1, 16'd1);
        slot(1'b1, 1, 6, 24'h400000, 24'hC00000, 24'h400000, 24'hC00000, 2'd2, 1'b0, 16'd1);

        // Full stop with a full FIFO flushed on the IDLE edge.
        slot(1'b0, 1, 0, 24'h400000, 24'hC00000, 24'h300000, 24'hD00000, 2'd3, 1'b0, 16'd1);
        slot(1'b0, 1, 0, 24'h400000, 24'hC00000, 24'h200000, 24'hE00000, 2'd3, 1'b0, 16'd1);
        slot(1'b0, 1, 0, 24'h400000, 24'hC00000, 24'h100000, 24'hF00000, 2'd3, 1'b0, 16'd1);
        slot(1'b0, 2, 0, 24'h400000, 24'hC00000, 24'h000000, 24'h000000, 2'd0, 1'b0, 16'd1);
        slot(1'b0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 2'd0, 1'b0, 16'd1);
        slot(1'b1, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 2'd1, 1'b1, 16'd2);
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h200000, 24'h100000, 2'd1, 1'b0, 16'd2);

        // Reset in RAMP_UP at gain 128 with one sample buffered.
        push(24'h200000, 24'h200000);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_checks();

        // Restart must begin at gain 64 and must not see the pre-reset sample.
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h100000, 24'h080000, 2'd1, 1'b0, 16'd0);
        slot(1'b1, 1, 0, 24'h400000, 24'h200000, 24'h200000, 24'h100000, 2'd1, 1'b0, 16'd0);

        repeat (4) step();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_stream_scheduler.md
Name: dac_stream_scheduler

Overview:
- Sequences the stereo sigma-delta DAC core.
- Accepts 24-bit stereo PCM from the upstream audio path over a valid/ready handshake and buffers it in a 2-entry FIFO.
- Generates the modulator update strobe, holds each sample for OSR strobes, and applies a click-free linear gain ramp on start and stop.
- Counts FIFO underruns. Its outputs drive in_valid/in_l/in_r of the DAC core directly.

Parameters:
- DW, 24, sample width (signed two's complement).
- CLK_DIV, 4, clk cycles per modulator strobe (>=2).
- OSR, 64, modulator strobes per audio sample (power of two, >=2).
- RAMP_STEP, 4, gain increment per audio sample (power of two, divides 256).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = play, 0 = ramp down to silence.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  upstream sample ready.
- s_l  in  DW  left sample.
- s_r  in  DW  right sample.
- dac_valid  out  1  one-cycle modulator strobe.
- dac_l  out  DW  scaled left sample to the DAC.
- dac_r  out  DW  scaled right sample to the DAC.
- state  out  2  0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN.
- underrun  out  1  one-cycle pulse on underrun.
- underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; rst sampled high on a clk edge clears all state at that edge.
- Reset values:
  - dac_valid=0, dac_l=dac_r=0, state=IDLE, gain=0.
  - underrun=0, underrun_cnt=0, FIFO empty, div_cnt=0, osr_cnt=0.
  - s_ready=1 in the first cycle after reset.
- Strobe generation:
  - div_cnt counts 0..CLK_DIV-1 and wraps; tick = (div_cnt==CLK_DIV-1).
  - dac_valid is registered tick: high one cycle after each tick, every CLK_DIV cycles, in all states including IDLE so the modulator keeps running.
- Slot counting:
  - osr_cnt increments on tick and wraps at OSR-1.
  - boundary = tick && osr_cnt==OSR-1. The first boundary occurs CLK_DIV*OSR cycles after reset release.
- FIFO:
  - 2 entries, each {l,r}. s_ready = !full, independent of pop in the same cycle.
  - Push on s_valid && s_ready. Accepted in every state, so IDLE pre-fills.
- At each boundary:
  - Pop a sample only in RAMP_UP, RUN or RAMP_DOWN, after the state/gain update below.
  - If the FIFO is empty in those states, use sample=0, pulse underrun, and increment underrun_cnt (saturates at 0xFFFF).
  - In IDLE there is no pop and no underrun; dac_l/dac_r are loaded with 0.
- State/gain update, evaluated at boundary only, except the enable fall:
  - IDLE & enable: go to RAMP_UP, gain <= RAMP_STEP.
  - RAMP_UP: gain <= min(gain+RAMP_STEP, 256); go to RUN when the new gain reaches 256.
  - RUN: gain stays 256.
  - RAMP_DOWN: gain <= max(gain-RAMP_STEP, 0); go to IDLE when the new gain reaches 0, flushing the FIFO on that edge.
  - enable low while in RAMP_UP or RUN: go to RAMP_DOWN on the next clk edge. gain is unchanged until the next boundary.
  - enable high while in RAMP_DOWN: go to RAMP_UP on the next clk edge, continuing from the current gain.
- Scaling:
  - dac_x <= (sample * gain_new) >>> 8.
  - sample is signed DW; gain is unsigned 9-bit, 0..256. Use a signed DW+10 product with arithmetic shift, truncated to DW. There is no overflow since gain <= 256.
  - dac_l/dac_r update on the boundary edge, the same edge dac_valid rises. They are stable between boundaries.
- Simultaneous events:
  - Push and pop in the same cycle: both occur and the FIFO count is unchanged.
  - On the flush edge, a push in the same cycle is dropped.
  - rst overrides everything, including mid-ramp.

Decomposition:
- Package dac_ctrl_pkg holds:
  - the state encoding (IDLE/RAMP_UP/RUN/RAMP_DOWN);
  - GAIN_W=9 and GAIN_UNITY=256;
  - UCNT_W=16.
- One sub-module: stereo_fifo2, a 2-entry {l,r} FIFO with push, pop, flush, full and empty, and synchronous active-high rst.

Test Plan:
All scenarios use CLK_DIV=4, OSR=4, RAMP_STEP=64.
1. Reset: hold rst for 3 cycles. Then dac_l/dac_r=0, state=0, underrun_cnt=0 and s_ready=1. dac_valid pulses every 4 cycles from cycle 4 after release.
2. Ramp up: stream 0x400000 on both channels with enable=1. At successive boundaries dac_l = 0x100000, 0x200000, 0x300000, 0x400000, and state goes RAMP_UP then RUN on the 4th boundary.
3. Negative scaling: in RUN, send 0xC00000, then ramp down. At gain 128, dac_l=0xE00000 (arithmetic shift preserves sign).
4. Underrun: in RUN, stop s_valid. The next boundary gives dac_l=0, a one-cycle underrun pulse and underrun_cnt=1. Pushes resuming mid-slot play at the following boundary.
5. Stop/restart: drop enable in RUN. Gain steps 192, 128, 64, 0, then state=IDLE with the FIFO flushed. Re-raise enable at gain 128 during RAMP_DOWN; the ramp resumes 192 then 256.
6. Reset mid-ramp: assert rst during RAMP_UP at gain 128. The next cycle has gain 0, state IDLE, outputs 0 and an empty FIFO.
